// File: rtl/divider_arbiter_if.sv
// -----------------------------------------------------------------------------
// divider_arbiter_if
// Bundles the requester side (request/response) and the shared-divider side
// of divider_arbiter into one interface.
//   slave  : the arbiter's view (takes requests, drives the divider)
//   master : the environment's view (requesters plus the divider itself)
// Signals:
//   req_valid    per-requester request
//   req_ready    per-requester accept pulse
//   req_dividend packed dividends, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_divisor  packed divisors, same packing
//   rsp_valid    one-cycle response strobe to the owner
//   rsp_quotient shared response data, valid with rsp_valid
//   rsp_error    divide-by-zero or timeout flag, valid with rsp_valid
//   div_start    one-cycle start pulse to the divider
//   div_dividend / div_divisor operands to the divider
//   div_busy     divider cannot accept a start
//   div_done     divider result strobe
//   div_quotient divider result, valid with div_done
// -----------------------------------------------------------------------------
interface divider_arbiter_if #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 32
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_dividend;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_divisor;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0]         rsp_quotient;
  logic                          rsp_error;
  logic                          div_start;
  logic [DATA_WIDTH-1:0]         div_dividend;
  logic [DATA_WIDTH-1:0]         div_divisor;
  logic                          div_busy;
  logic                          div_done;
  logic [DATA_WIDTH-1:0]         div_quotient;

  modport slave (
    input  req_valid, req_dividend, req_divisor, div_busy, div_done, div_quotient,
    output req_ready, rsp_valid, rsp_quotient, rsp_error,
           div_start, div_dividend, div_divisor
  );

  modport master (
    output req_valid, req_dividend, req_divisor, div_busy, div_done, div_quotient,
    input  req_ready, rsp_valid, rsp_quotient, rsp_error,
           div_start, div_dividend, div_divisor
  );
endinterface

// File: rtl/divider_arbiter.sv
// -----------------------------------------------------------------------------
// divider_arbiter
// Shares one divider between NUM_REQ requesters. A round-robin pick in IDLE
// grants one requester, its operands are latched, the divider is started
// (unless the divisor is zero), the result or a timeout is captured, and a
// one-cycle response strobe goes back to the owner before the next grant.
//
// Ports:
//   clk    clock
//   reset  asynchronous, active-high reset
//   bus    divider_arbiter_if.slave (requester and divider signals)
// Parameters:
//   NUM_REQ    number of requesters (must match the interface instance)
//   DATA_WIDTH operand / quotient width (must match the interface instance)
//   TIMEOUT    WAIT cycles allowed before the transaction ends with an error
//
// Timing with a divider that answers the cycle after div_start:
//   cycle 1 req_ready (IDLE), cycle 2 div_start (ISSUE), cycle 3 div_done
//   (WAIT), cycle 4 rsp_valid (RESPOND); the next grant is cycle 5 at the
//   earliest.
// -----------------------------------------------------------------------------
module divider_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic             clk,
  input  logic             reset,
  divider_arbiter_if.slave bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  // Value the counter holds during the TIMEOUT-th WAIT cycle (it is 0 in the
  // first), i.e. the cycle in which the count reaches TIMEOUT.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESPOND
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [IDX_W-1:0]      ptr;
  logic [IDX_W-1:0]      owner;
  logic [DATA_WIDTH-1:0] dividend_q;
  logic [DATA_WIDTH-1:0] divisor_q;
  logic [CNT_W-1:0]      cnt;
  logic [DATA_WIDTH-1:0] quotient_q;
  logic                  error_q;

  logic                  grant_found;
  logic [IDX_W-1:0]      grant_idx;
  int                    cand;
  logic [NUM_REQ-1:0]    ready;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic                  start;

  // Per-requester operand views of the packed buses.
  logic [DATA_WIDTH-1:0] dividend_arr [NUM_REQ];
  logic [DATA_WIDTH-1:0] divisor_arr  [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign dividend_arr[g] = bus.req_dividend[g*DATA_WIDTH +: DATA_WIDTH];
    assign divisor_arr[g]  = bus.req_divisor[g*DATA_WIDTH +: DATA_WIDTH];
  end

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    return (int'(idx) == NUM_REQ - 1) ? '0 : idx + 1'b1;
  endfunction

  // Round-robin search ptr, ptr+1, ... modulo NUM_REQ. Walking the offsets
  // from farthest to nearest lets the nearest requesting index win.
  always_comb begin
    // NOTE: every variable gets a default before any conditional assignment,
    // so no path leaves a value unassigned and no latch is inferred.
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = int'(ptr) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (bus.req_valid[IDX_W'(cand)]) begin
        grant_found = 1'b1;
        grant_idx   = IDX_W'(cand);
      end
    end
  end

  // Next state and control outputs.
  always_comb begin
    state_next = state;
    ready      = '0;
    rsp_valid  = '0;
    start      = 1'b0;
    case (state)
      IDLE: begin
        if (grant_found) begin
          state_next = ISSUE;
          // The grant is only taken when not in reset, so it is not shown then.
          if (!reset) ready[grant_idx] = 1'b1;
        end
      end
      ISSUE: begin
        if (divisor_q == '0) begin
          state_next = RESPOND;
        end else if (!bus.div_busy) begin
          start      = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (bus.div_done || cnt == CNT_LAST) state_next = RESPOND;
      end
      RESPOND: begin
        rsp_valid[owner] = 1'b1;
        state_next       = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      ptr        <= '0;
      owner      <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      cnt        <= '0;
      quotient_q <= '0;
      error_q    <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (grant_found) begin
            owner      <= grant_idx;
            dividend_q <= dividend_arr[grant_idx];
            divisor_q  <= divisor_arr[grant_idx];
          end
        end
        ISSUE: begin
          if (divisor_q == '0) begin
            quotient_q <= '0;
            error_q    <= 1'b1;
          end else if (start) begin
            cnt <= '0;
          end
        end
        WAIT: begin
          cnt <= cnt + 1'b1;
          // A result arriving in the timeout cycle still counts as a result.
          if (bus.div_done) begin
            quotient_q <= bus.div_quotient;
            error_q    <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            quotient_q <= '0;
            error_q    <= 1'b1;
          end
        end
        RESPOND: ptr <= next_idx(owner);
        default: ;
      endcase
    end
  end

  assign bus.req_ready    = ready;
  assign bus.rsp_valid    = rsp_valid;
  assign bus.rsp_quotient = quotient_q;
  assign bus.rsp_error    = error_q;
  assign bus.div_start    = start;
  assign bus.div_dividend = dividend_q;
  assign bus.div_divisor  = divisor_q;

endmodule

// File: tb/tb_divider_arbiter.sv
// -----------------------------------------------------------------------------
// tb_divider_arbiter
// Directed bench for divider_arbiter: two requesters and a behavioural
// divider whose answer latency is programmable (or disabled). Inputs change
// 1 ns after the rising edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_divider_arbiter;

  localparam int NUM_REQ = 2;
  localparam int DW      = 32;
  localparam int TIMEOUT = 255;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  divider_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DW)) bus ();

  divider_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .DATA_WIDTH(DW),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  // Requester model
  logic [NUM_REQ-1:0] valid_drv = '0;
  logic [NUM_REQ-1:0] drop_mask = '0;
  bit                 auto_drop = 1'b1;
  logic [DW-1:0]      dvd [NUM_REQ];
  logic [DW-1:0]      dvs [NUM_REQ];

  // Divider model
  bit            dm_enable  = 1'b1;
  int            dm_delay   = 1;
  bit            dm_pending = 1'b0;
  int            dm_done_at = 0;
  logic [DW-1:0] dm_result  = '0;
  bit            busy_drv   = 1'b0;

  // Observations
  int  ready_cyc, rsp_cyc, start_cyc;
  int  start_count = 0;
  int  rsp_count   = 0;
  int  onehot_bad  = 0;
  bit  rsp_now;
  int  grant_q[$];
  int  rsp_owner_q[$];
  int  rsp_data_q[$];
  int  ready_cyc_q[$];
  int  rsp_cyc_q[$];

  // One clock: drive inputs just after the edge, observe on the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    valid_drv     = valid_drv & ~drop_mask;
    drop_mask     = '0;
    bus.req_valid = valid_drv;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_dividend[i*DW +: DW] = dvd[i];
      bus.req_divisor[i*DW +: DW]  = dvs[i];
    end
    bus.div_busy = busy_drv;
    if (dm_enable && dm_pending && cyc == dm_done_at) begin
      bus.div_done     = 1'b1;
      bus.div_quotient = dm_result;
      dm_pending       = 1'b0;
    end else begin
      bus.div_done     = 1'b0;
      bus.div_quotient = 32'hDEAD_BEEF;
    end
    @(negedge clk);
    rsp_now = 1'b0;
    if ($countones(bus.req_ready) > 1) onehot_bad++;
    if (bus.req_ready != '0) begin
      ready_cyc = cyc;
      grant_q.push_back(bus.req_ready[1] ? 1 : 0);
      ready_cyc_q.push_back(cyc);
      if (auto_drop) drop_mask = bus.req_ready;
    end
    if (bus.div_start) begin
      start_count++;
      start_cyc  = cyc;
      dm_pending = 1'b1;
      dm_done_at = cyc + dm_delay;
      dm_result  = (bus.div_divisor != '0) ? bus.div_dividend / bus.div_divisor : '0;
    end
    if (bus.rsp_valid != '0) begin
      rsp_now = 1'b1;
      rsp_count++;
      rsp_cyc = cyc;
      rsp_owner_q.push_back(int'(bus.rsp_valid));
      rsp_data_q.push_back(int'(bus.rsp_quotient));
      rsp_cyc_q.push_back(cyc);
    end
  endtask

  task automatic wait_rsp(input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      step();
      if (rsp_now) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    tests_run++;
    if (bus.req_ready !== 2'b00) begin tests_failed++; $display("FAIL reset_req_ready: got %b expected 00", bus.req_ready); end
    tests_run++;
    if (bus.rsp_valid !== 2'b00) begin tests_failed++; $display("FAIL reset_rsp_valid: got %b expected 00", bus.rsp_valid); end
    tests_run++;
    if (bus.div_start !== 1'b0) begin tests_failed++; $display("FAIL reset_div_start: got %b expected 0", bus.div_start); end
    tests_run++;
    if (bus.div_dividend !== 32'h0) begin tests_failed++; $display("FAIL reset_div_dividend: got %h expected 0", bus.div_dividend); end
    tests_run++;
    if (bus.div_divisor !== 32'h0) begin tests_failed++; $display("FAIL reset_div_divisor: got %h expected 0", bus.div_divisor); end
    tests_run++;
    if (bus.rsp_quotient !== 32'h0) begin tests_failed++; $display("FAIL reset_rsp_quotient: got %h expected 0", bus.rsp_quotient); end
    tests_run++;
    if (bus.rsp_error !== 1'b0) begin tests_failed++; $display("FAIL reset_rsp_error: got %b expected 0", bus.rsp_error); end
    reset = 1'b0;
  endtask

  task automatic test_single();
    bit ok;
    int sc0;
    sc0       = start_count;
    dm_delay  = 1;
    dvd[0]    = 32'h1000;
    dvs[0]    = 32'h400;
    valid_drv = 2'b01;
    step();
    tests_run++;
    if (bus.req_ready !== 2'b01) begin tests_failed++; $display("FAIL single_req_ready: got %b expected 01", bus.req_ready); end
    step();
    tests_run++;
    if (bus.div_start !== 1'b1) begin tests_failed++; $display("FAIL single_div_start: got %b expected 1", bus.div_start); end
    tests_run++;
    if (bus.div_dividend !== 32'h1000 || bus.div_divisor !== 32'h400) begin
      tests_failed++;
      $display("FAIL single_operands: got %h/%h expected 00001000/00000400", bus.div_dividend, bus.div_divisor);
    end
    wait_rsp(10, ok);
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL single_rsp_seen: got none expected rsp_valid within 10 cycles"); end
    tests_run++;
    if (rsp_cyc - ready_cyc != 3) begin tests_failed++; $display("FAIL single_latency: got %0d expected 3 edges", rsp_cyc - ready_cyc); end
    tests_run++;
    if (bus.rsp_valid !== 2'b01) begin tests_failed++; $display("FAIL single_rsp_valid: got %b expected 01", bus.rsp_valid); end
    tests_run++;
    if (bus.rsp_quotient !== 32'h4) begin tests_failed++; $display("FAIL single_quotient: got %h expected 00000004", bus.rsp_quotient); end
    tests_run++;
    if (bus.rsp_error !== 1'b0) begin tests_failed++; $display("FAIL single_error: got %b expected 0", bus.rsp_error); end
    tests_run++;
    if (start_count - sc0 != 1) begin tests_failed++; $display("FAIL single_start_count: got %0d expected 1", start_count - sc0); end
    step();
    tests_run++;
    if (bus.rsp_valid !== 2'b00 || bus.rsp_quotient !== 32'h4) begin
      tests_failed++;
      $display("FAIL single_after_rsp: got valid %b data %h expected 00 / 00000004", bus.rsp_valid, bus.rsp_quotient);
    end
  endtask

  task automatic test_divide_by_zero();
    bit ok;
    int sc0;
    sc0       = start_count;
    dvd[1]    = 32'h55;
    dvs[1]    = 32'h0;
    valid_drv = 2'b10;
    step();
    tests_run++;
    if (bus.req_ready !== 2'b10) begin tests_failed++; $display("FAIL dbz_req_ready: got %b expected 10", bus.req_ready); end
    wait_rsp(10, ok);
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL dbz_rsp_seen: got none expected rsp_valid within 10 cycles"); end
    tests_run++;
    if (rsp_cyc - ready_cyc != 2) begin tests_failed++; $display("FAIL dbz_latency: got %0d expected 2 edges", rsp_cyc - ready_cyc); end
    tests_run++;
    if (bus.rsp_valid !== 2'b10) begin tests_failed++; $display("FAIL dbz_rsp_valid: got %b expected 10", bus.rsp_valid); end
    tests_run++;
    if (bus.rsp_quotient !== 32'h0 || bus.rsp_error !== 1'b1) begin
      tests_failed++;
      $display("FAIL dbz_result: got %h err %b expected 00000000 err 1", bus.rsp_quotient, bus.rsp_error);
    end
    tests_run++;
    if (start_count != sc0) begin tests_failed++; $display("FAIL dbz_no_start: got %0d starts expected 0", start_count - sc0); end
  endtask

  task automatic test_round_robin();
    int exp_grant[4] = '{0, 1, 0, 1};
    int exp_owner[4] = '{1, 2, 1, 2};
    int exp_data[4]  = '{14, 100, 14, 100};
    int base;
    grant_q.delete(); rsp_owner_q.delete(); rsp_data_q.delete();
    ready_cyc_q.delete(); rsp_cyc_q.delete();
    dvd[0] = 32'd100;  dvs[0] = 32'd7;
    dvd[1] = 32'd1000; dvs[1] = 32'd10;
    auto_drop = 1'b0;
    valid_drv = 2'b11;
    base      = rsp_count;
    for (int k = 0; k < 60 && rsp_count - base < 4; k++) step();
    valid_drv = 2'b00;
    auto_drop = 1'b1;
    step();
    step();
    tests_run++;
    if (grant_q.size() != 4 || rsp_owner_q.size() != 4) begin
      tests_failed++;
      $display("FAIL rr_counts: got %0d grants %0d responses expected 4/4", grant_q.size(), rsp_owner_q.size());
    end
    for (int k = 0; k < 4; k++) begin
      tests_run++;
      if (k >= grant_q.size() || grant_q[k] != exp_grant[k] || rsp_owner_q[k] != exp_owner[k] || rsp_data_q[k] != exp_data[k]) begin
        tests_failed++;
        $display("FAIL rr_txn%0d: got grant %0d owner %0d data %0d expected %0d/%0d/%0d", k,
                 (k < grant_q.size()) ? grant_q[k] : -1, (k < rsp_owner_q.size()) ? rsp_owner_q[k] : -1,
                 (k < rsp_data_q.size()) ? rsp_data_q[k] : -1, exp_grant[k], exp_owner[k], exp_data[k]);
      end
    end
    for (int k = 1; k < 4 && k < ready_cyc_q.size() && k < rsp_cyc_q.size(); k++) begin
      tests_run++;
      if (ready_cyc_q[k] != rsp_cyc_q[k-1] + 1) begin
        tests_failed++;
        $display("FAIL rr_gap%0d: got grant at %0d expected %0d", k, ready_cyc_q[k], rsp_cyc_q[k-1] + 1);
      end
    end
  endtask

  task automatic test_timeout();
    bit ok;
    dm_enable = 1'b0;
    dvd[0]    = 32'h9000;
    dvs[0]    = 32'h3;
    valid_drv = 2'b01;
    wait_rsp(300, ok);
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL timeout_rsp_seen: got none expected rsp_valid within 300 cycles"); end
    tests_run++;
    if (rsp_cyc - start_cyc != 256) begin tests_failed++; $display("FAIL timeout_wait_len: got %0d expected 256", rsp_cyc - start_cyc); end
    tests_run++;
    if (bus.rsp_valid !== 2'b01 || bus.rsp_quotient !== 32'h0 || bus.rsp_error !== 1'b1) begin
      tests_failed++;
      $display("FAIL timeout_result: got %b %h %b expected 01 00000000 1", bus.rsp_valid, bus.rsp_quotient, bus.rsp_error);
    end
    dm_enable  = 1'b1;
    dm_pending = 1'b0;
    dvd[1]     = 32'hF0;
    dvs[1]     = 32'hF;
    valid_drv  = 2'b10;
    wait_rsp(10, ok);
    tests_run++;
    if (!ok || rsp_cyc - ready_cyc != 3) begin tests_failed++; $display("FAIL after_timeout_latency: got %0d ok %b expected 3 ok 1", rsp_cyc - ready_cyc, ok); end
    tests_run++;
    if (bus.rsp_valid !== 2'b10 || bus.rsp_quotient !== 32'h10 || bus.rsp_error !== 1'b0) begin
      tests_failed++;
      $display("FAIL after_timeout_result: got %b %h %b expected 10 00000010 0", bus.rsp_valid, bus.rsp_quotient, bus.rsp_error);
    end
  endtask

  task automatic test_done_at_timeout();
    bit ok;
    dm_delay  = 255;
    dvd[0]    = 32'h1234_5678;
    dvs[0]    = 32'h10;
    valid_drv = 2'b01;
    wait_rsp(300, ok);
    tests_run++;
    if (!ok || rsp_cyc - start_cyc != 256) begin tests_failed++; $display("FAIL tie_wait_len: got %0d ok %b expected 256 ok 1", rsp_cyc - start_cyc, ok); end
    tests_run++;
    if (bus.rsp_quotient !== 32'h0123_4567 || bus.rsp_error !== 1'b0) begin
      tests_failed++;
      $display("FAIL tie_result: got %h err %b expected 01234567 err 0", bus.rsp_quotient, bus.rsp_error);
    end
    dm_delay = 1;
  endtask

  task automatic test_busy();
    bit ok;
    int sc0;
    sc0       = start_count;
    busy_drv  = 1'b1;
    dvd[1]    = 32'h7FFF_FFFF;
    dvs[1]    = 32'h100;
    valid_drv = 2'b10;
    step();
    tests_run++;
    if (bus.req_ready !== 2'b10) begin tests_failed++; $display("FAIL busy_req_ready: got %b expected 10", bus.req_ready); end
    for (int k = 0; k < 5; k++) begin
      step();
      tests_run++;
      if (bus.div_start !== 1'b0) begin tests_failed++; $display("FAIL busy_withheld%0d: got %b expected 0", k, bus.div_start); end
    end
    busy_drv = 1'b0;
    step();
    tests_run++;
    if (bus.div_start !== 1'b1) begin tests_failed++; $display("FAIL busy_release_start: got %b expected 1", bus.div_start); end
    step();
    tests_run++;
    if (bus.div_start !== 1'b0) begin tests_failed++; $display("FAIL busy_single_pulse: got %b expected 0", bus.div_start); end
    wait_rsp(10, ok);
    tests_run++;
    if (!ok || bus.rsp_quotient !== 32'h007F_FFFF || start_count - sc0 != 1) begin
      tests_failed++;
      $display("FAIL busy_result: got %h starts %0d ok %b expected 007fffff starts 1 ok 1", bus.rsp_quotient, start_count - sc0, ok);
    end
  endtask

  task automatic test_reset_in_wait();
    bit ok;
    int rc0;
    int sc0;
    // Complete a requester-0 transaction so the pointer moves to 1.
    dvd[0]    = 32'h64;
    dvs[0]    = 32'h5;
    valid_drv = 2'b01;
    wait_rsp(10, ok);
    tests_run++;
    if (!ok || bus.rsp_quotient !== 32'h14) begin tests_failed++; $display("FAIL riw_setup: got %h ok %b expected 00000014 ok 1", bus.rsp_quotient, ok); end
    // Requester 1 reaches WAIT with a slow divider, then reset hits.
    dm_delay  = 8;
    dvd[1]    = 32'h500;
    dvs[1]    = 32'h10;
    valid_drv = 2'b10;
    step();
    step();
    step();
    step();
    rc0   = rsp_count;
    reset = 1'b1;
    step();
    tests_run++;
    if (bus.req_ready !== 2'b00 || bus.rsp_valid !== 2'b00 || bus.div_start !== 1'b0) begin
      tests_failed++;
      $display("FAIL riw_ctrl: got ready %b rsp %b start %b expected 00 00 0", bus.req_ready, bus.rsp_valid, bus.div_start);
    end
    tests_run++;
    if (bus.div_dividend !== 32'h0 || bus.div_divisor !== 32'h0 || bus.rsp_quotient !== 32'h0 || bus.rsp_error !== 1'b0) begin
      tests_failed++;
      $display("FAIL riw_data: got %h %h %h %b expected all 0", bus.div_dividend, bus.div_divisor, bus.rsp_quotient, bus.rsp_error);
    end
    step();
    reset = 1'b0;
    sc0   = start_count;
    // The divider's answer lands while the block idles after reset.
    for (int k = 0; k < 6; k++) step();
    tests_run++;
    if (rsp_count != rc0 || start_count != sc0) begin
      tests_failed++;
      $display("FAIL riw_no_rsp: got %0d rsp %0d starts expected 0/0", rsp_count - rc0, start_count - sc0);
    end
    tests_run++;
    if (bus.rsp_quotient !== 32'h0 || bus.rsp_error !== 1'b0) begin
      tests_failed++;
      $display("FAIL riw_stale_done: got %h err %b expected 00000000 err 0", bus.rsp_quotient, bus.rsp_error);
    end
    dm_delay  = 1;
    dvd[0]    = 32'h3C;
    dvs[0]    = 32'h4;
    valid_drv = 2'b11;
    step();
    tests_run++;
    if (bus.req_ready !== 2'b01) begin tests_failed++; $display("FAIL riw_ptr_reset: got %b expected 01", bus.req_ready); end
    wait_rsp(10, ok);
    valid_drv = 2'b00;
    tests_run++;
    if (!ok || bus.rsp_valid !== 2'b01 || bus.rsp_quotient !== 32'hF) begin
      tests_failed++;
      $display("FAIL riw_resume: got %b %h ok %b expected 01 0000000f ok 1", bus.rsp_valid, bus.rsp_quotient, ok);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected end of run before 2 ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset            = 1'b1;
    bus.req_valid    = '0;
    bus.req_dividend = '0;
    bus.req_divisor  = '0;
    bus.div_busy     = 1'b0;
    bus.div_done     = 1'b0;
    bus.div_quotient = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      dvd[i] = '0;
      dvs[i] = '0;
    end
    test_reset();
    test_single();
    test_divide_by_zero();
    test_round_robin();
    test_timeout();
    test_done_at_timeout();
    test_busy();
    test_reset_in_wait();
    tests_run++;
    if (onehot_bad != 0) begin tests_failed++; $display("FAIL ready_onehot: got %0d multi-bit cycles expected 0", onehot_bad); end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/divider_arbiter.md
DIVIDER_ARBITER -- requirements
Module: divider_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 2: number of requesters sharing the divider.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32: operand and quotient width, Q-format as produced by the demod path.
REQ-003 The block SHALL have parameter TIMEOUT, default 255: maximum WAIT cycles before error.
REQ-004 The block SHALL have port clk  in  1  clock.
REQ-005 The block SHALL have port reset  in  1  reset, asynchronous, active-high.
REQ-006 The block SHALL have port req_valid  in  NUM_REQ  per-requester request.
REQ-007 The block SHALL have port req_ready  out  NUM_REQ  per-requester accept pulse.
REQ-008 The block SHALL have port req_dividend  in  NUM_REQ*DATA_WIDTH  packed dividends, requester i at [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 The block SHALL have port req_divisor  in  NUM_REQ*DATA_WIDTH  packed divisors, same packing.
REQ-010 The block SHALL have port rsp_valid  out  NUM_REQ  one-cycle response strobe to the owner.
REQ-011 The block SHALL have port rsp_quotient  out  DATA_WIDTH  shared response data, valid with rsp_valid.
REQ-012 The block SHALL have port rsp_error  out  1  divide-by-zero or timeout flag, valid with rsp_valid.
REQ-013 The block SHALL have ports div_start  out  1, div_dividend  out  DATA_WIDTH and div_divisor  out  DATA_WIDTH  to the shared divider.
REQ-014 The block SHALL have ports div_busy  in  1, div_done  in  1 and div_quotient  in  DATA_WIDTH  from the shared divider.

Function
REQ-015 The block SHALL implement the states IDLE, ISSUE, WAIT and RESPOND.
REQ-016 In IDLE with any req_valid set, the block SHALL pick a winner round-robin from priority pointer ptr, assert req_ready[winner] for that cycle only, latch the winner's operands and index, and go to ISSUE.
REQ-017 Round-robin SHALL search ptr, ptr+1, ... modulo NUM_REQ; ptr SHALL become winner+1 modulo NUM_REQ on leaving RESPOND.
REQ-018 At most one req_ready bit SHALL be high in any cycle, and only in IDLE.
REQ-019 Requesters SHALL hold req_valid and operands stable until req_ready; the block SHALL NOT accept a new request before the current RESPOND completes.
REQ-020 In ISSUE with a latched divisor of 0, the block SHALL NOT start the divider and SHALL go to RESPOND with quotient 0 and error 1.
REQ-021 In ISSUE with a nonzero divisor and div_busy=0, the block SHALL pulse div_start for exactly one cycle with div_dividend/div_divisor driven from the latched operands, clear the timeout counter and go to WAIT; if div_busy=1 it SHALL stay in ISSUE with div_start=0.
REQ-022 div_dividend and div_divisor SHALL hold the latched operands from ISSUE through WAIT.
REQ-023 In WAIT the counter SHALL increment each cycle; on div_done the block SHALL register div_quotient with error 0 and go to RESPOND.
REQ-024 If the counter reaches TIMEOUT without div_done, the block SHALL go to RESPOND with quotient 0 and error 1; if div_done and timeout occur in the same cycle, div_done SHALL win.
REQ-025 div_done SHALL be ignored outside WAIT.
REQ-026 In RESPOND the block SHALL assert rsp_valid[owner] for one cycle with registered rsp_quotient/rsp_error, then return to IDLE.
REQ-027 Outside RESPOND, rsp_valid SHALL be 0; rsp_quotient and rsp_error SHALL hold their last values.
REQ-028 Minimum latency SHALL be 4 cycles, req_ready to rsp_valid, for a divider that asserts div_done the cycle after div_start; the next request SHALL be granted no earlier than the cycle after rsp_valid.

Reset
REQ-029 On reset the block SHALL set state to IDLE, ptr to 0, the counter to 0, and req_ready, rsp_valid, rsp_quotient, rsp_error, div_start, div_dividend and div_divisor to 0.
REQ-030 Reset mid-operation SHALL abandon the transaction without any rsp_valid; a div_done that arrives after reset while in IDLE SHALL be ignored.

Verification
REQ-031 The bench SHALL cover: req_valid=01, dividend 0x1000, divisor 0x400, divider done 1 cycle after start -> req_ready=01, single div_start, rsp_valid=01 4 cycles after req_ready, quotient equals the divider output, error 0.
REQ-032 The bench SHALL cover: req_valid=11 held continuously for 4 transactions -> grants in order 0,1,0,1, with exactly one rsp_valid per grant to the matching requester.
REQ-033 The bench SHALL cover: divisor 0 from requester 1 -> no div_start, rsp_valid=10, quotient 0, error 1.
REQ-034 The bench SHALL cover: divider never asserts div_done, TIMEOUT=255 -> rsp_valid after 255 WAIT cycles with error 1, then the next request is served normally.
REQ-035 The bench SHALL cover: div_busy=1 for 5 cycles in ISSUE -> div_start withheld, then one div_start pulse the cycle div_busy falls.
REQ-036 The bench SHALL cover: reset asserted in WAIT, then a stale div_done -> outputs at reset values, no rsp_valid, ptr=0.
